regfile_write_buffer: RTL and testbench

Write-side companion to the 32-entry, 32-bit register file read muxes. It accepts register write requests over a valid/ready handshake and queues them in an in-order FIFO. Each queued write drains into a 32 x 32-bit register array through a 5-to-32 one-hot decoder. The full array is exported flat so the existing 32:1 read mux trees can select from it. A pending-write mask is exported for hazard detection.

---
 rtl/regfile_write_buffer_if.sv | 13 +
 rtl/regfile_write_buffer.sv | 114 +++++++++++
 tb/tb_regfile_write_buffer.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/regfile_write_buffer_if.sv
// Write-request handshake into regfile_write_buffer: a valid/ready pair
// carrying a destination register index and its data.
interface regfile_write_buffer_if #(
    parameter int unsigned WIDTH = 32
);
    logic             wr_valid;
    logic             wr_ready;
    logic [4:0]       wr_addr;
    logic [WIDTH-1:0] wr_data;

    modport master (output wr_valid, output wr_addr, output wr_data, input wr_ready);
    modport slave  (input wr_valid, input wr_addr, input wr_data, output wr_ready);
endinterface

// File: rtl/regfile_write_buffer.sv
// In-order write FIFO that drains into a 32 x WIDTH register array, with the
// flat array, per-commit one-hot enable and pending-write mask exported.
module regfile_write_buffer #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 32
) (
    input  logic                     clock,
    input  logic                     reset_n,
    regfile_write_buffer_if.slave    wr,
    input  logic                     drain_en,
    output logic [32*WIDTH-1:0]      regs_out,
    output logic [31:0]              wr_onehot,
    output logic [31:0]              pending,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     empty,
    output logic                     full
);
    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    logic [4:0]       addr_q [DEPTH];
    logic [4:0]       addr_d [DEPTH];
    logic [WIDTH-1:0] data_q [DEPTH];
    logic [WIDTH-1:0] data_d [DEPTH];
    logic [WIDTH-1:0] regs_q [32];
    logic [WIDTH-1:0] regs_d [32];
    logic [PW-1:0]    head_q, head_d, tail_q, tail_d;
    logic [CW-1:0]    count_q, count_d;
    logic             push, pop;
    logic [4:0]       head_addr;
    logic [WIDTH-1:0] head_data;
    logic [PW-1:0]    slot;

    assign count       = count_q;
    assign empty       = (count_q == '0);
    assign full        = (count_q == CW'(DEPTH));
    assign wr.wr_ready = !full;
    assign push        = wr.wr_valid && wr.wr_ready;
    assign pop         = drain_en && !empty;
    assign head_addr   = addr_q[head_q];
    assign head_data   = data_q[head_q];

    always_comb begin
        addr_d  = addr_q;
        data_d  = data_q;
        tail_d  = tail_q;
        head_d  = head_q;
        count_d = count_q;
        if (push) begin
            addr_d[tail_q] = wr.wr_addr;
            data_d[tail_q] = wr.wr_data;
            tail_d         = tail_q + PW'(1);
        end
        if (pop) begin
            head_d = head_q + PW'(1);
        end
        if (push && !pop) begin
            count_d = count_q + CW'(1);
        end else if (pop && !push) begin
            count_d = count_q - CW'(1);
        end
    end

    // Commits to register 0 still pop the entry but never write or decode.
    always_comb begin
        regs_d    = regs_q;
        wr_onehot = '0;
        if (pop && head_addr != 5'd0) begin
            regs_d[head_addr]    = head_data;
            wr_onehot[head_addr] = 1'b1;
        end
    end

    always_comb begin
        pending = '0;
        slot    = '0;
        for (int unsigned k = 0; k < DEPTH; k++) begin
            slot = head_q + PW'(k);
            if (k < 32'(count_q)) begin
                pending[addr_q[slot]] = 1'b1;
            end
        end
        pending[0] = 1'b0;
    end

    always_comb begin
        regs_out = '0;
        for (int unsigned r = 0; r < 32; r++) begin
            regs_out[r*WIDTH +: WIDTH] = regs_q[r];
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                addr_q[i] <= '0;
                data_q[i] <= '0;
            end
            for (int unsigned r = 0; r < 32; r++) begin
                regs_q[r] <= '0;
            end
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            regs_q  <= regs_d;
        end
    end
endmodule

// File: tb/tb_regfile_write_buffer.sv
// Directed plus randomized bench for regfile_write_buffer against a
// queue-and-array reference model.
module tb_regfile_write_buffer;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned WIDTH = 32;

    logic                   clock = 1'b0;
    logic                   reset_n = 1'b0;
    logic                   drain_en = 1'b0;
    logic [32*WIDTH-1:0]    regs_out;
    logic [31:0]            wr_onehot;
    logic [31:0]            pending;
    logic [$clog2(DEPTH):0] count;
    logic                   empty;
    logic                   full;

    regfile_write_buffer_if #(.WIDTH(WIDTH)) wif ();

    regfile_write_buffer #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .wr        (wif.slave),
        .drain_en  (drain_en),
        .regs_out  (regs_out),
        .wr_onehot (wr_onehot),
        .pending   (pending),
        .count     (count),
        .empty     (empty),
        .full      (full)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int failures = 0;

    logic [36:0]      mq [$];
    logic [WIDTH-1:0] mregs [32];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] exp_pending();
        logic [31:0] p;
        p = '0;
        foreach (mq[i]) p[mq[i][36:32]] = 1'b1;
        p[0] = 1'b0;
        return p;
    endfunction

    task automatic chk_regs(input string tag);
        for (int r = 0; r < 32; r++) begin
            chk($sformatf("%s_reg%0d", tag, r), 64'(regs_out[r*WIDTH +: WIDTH]), 64'(mregs[r]));
        end
    endtask

    task automatic chk_state(input string tag);
        logic [31:0] oh;
        oh = '0;
        if (drain_en && mq.size() > 0 && mq[0][36:32] != 5'd0) oh = 32'd1 << mq[0][36:32];
        chk({tag, "_ready"}, 64'(wif.wr_ready), 64'(mq.size() < DEPTH));
        chk({tag, "_full"}, 64'(full), 64'(mq.size() == DEPTH));
        chk({tag, "_empty"}, 64'(empty), 64'(mq.size() == 0));
        chk({tag, "_count"}, 64'(count), 64'(mq.size()));
        chk({tag, "_pending"}, 64'(pending), 64'(exp_pending()));
        chk({tag, "_onehot"}, 64'(wr_onehot), 64'(oh));
        chk_regs(tag);
    endtask

    // Called at a negedge: drive, check pre-edge outputs, advance the model.
    task automatic step(input bit v, input logic [4:0] a, input logic [31:0] d,
                        input bit dr, output bit acc);
        bit          pop_l;
        logic [36:0] h;
        wif.wr_valid = v;
        wif.wr_addr  = a;
        wif.wr_data  = d;
        drain_en     = dr;
        #1;
        chk_state("step");
        acc   = v && (mq.size() < DEPTH);
        pop_l = dr && (mq.size() > 0);
        @(posedge clock);
        if (pop_l) begin
            h = mq.pop_front();
            if (h[36:32] != 5'd0) mregs[h[36:32]] = h[31:0];
        end
        if (acc) mq.push_back({a, d});
        @(negedge clock);
    endtask

    initial begin
        bit          acc;
        bit          hv;
        logic [4:0]  ha;
        logic [31:0] hd;

        for (int r = 0; r < 32; r++) mregs[r] = '0;
        wif.wr_valid = 1'b0;
        wif.wr_addr  = '0;
        wif.wr_data  = '0;
        #1;
        chk_state("reset");
        @(negedge clock);
        reset_n = 1'b1;

        // Single write with immediate drain
        step(1'b1, 5'd5, 32'hDEADBEEF, 1'b1, acc);
        #1;
        chk("single_pending5", 64'(pending[5]), 64'd1);
        chk("single_onehot", 64'(wr_onehot), 64'h20);
        step(1'b0, 5'd0, 32'd0, 1'b1, acc);
        chk("single_word5", 64'(regs_out[5*WIDTH +: WIDTH]), 64'hDEADBEEF);
        chk("single_pending_clear", 64'(pending), 64'd0);

        // Register 0 is popped and discarded
        step(1'b1, 5'd0, 32'hFFFFFFFF, 1'b1, acc);
        chk("r0_count1", 64'(count), 64'd1);
        chk("r0_onehot", 64'(wr_onehot), 64'd0);
        step(1'b0, 5'd0, 32'd0, 1'b1, acc);
        chk("r0_count0", 64'(count), 64'd0);
        chk("r0_word0", 64'(regs_out[WIDTH-1:0]), 64'd0);

        // Fill, backpressure, then one pop frees a slot
        for (int i = 1; i <= 4; i++) step(1'b1, 5'(i), 32'(32'h100 + i), 1'b0, acc);
        chk("full_flag", 64'(full), 64'd1);
        chk("full_ready", 64'(wif.wr_ready), 64'd0);
        chk("full_pending", 64'(pending), 64'h1E);
        step(1'b1, 5'd9, 32'h55, 1'b0, acc);
        chk("full_refused", 64'(acc), 64'd0);
        step(1'b1, 5'd9, 32'h55, 1'b1, acc);
        chk("full_pop_only", 64'(count), 64'd3);
        step(1'b1, 5'd9, 32'h55, 1'b0, acc);
        chk("full_fifth_acc", 64'(acc), 64'd1);
        for (int i = 0; i < 4; i++) step(1'b0, 5'd0, 32'd0, 1'b1, acc);

        // Concurrent push/pop wraps the pointers
        step(1'b1, 5'd10, 32'hA0, 1'b0, acc);
        for (int i = 0; i < 6; i++) begin
            step(1'b1, 5'(11 + i), 32'(32'hB0 + i), 1'b1, acc);
            chk("conc_count", 64'(count), 64'd1);
        end
        step(1'b0, 5'd0, 32'd0, 1'b1, acc);

        // Same-address ordering: last write wins
        for (int i = 1; i <= 3; i++) step(1'b1, 5'd7, 32'(i), 1'b0, acc);
        for (int i = 1; i <= 3; i++) begin
            step(1'b0, 5'd0, 32'd0, 1'b1, acc);
            chk("same7_word", 64'(regs_out[7*WIDTH +: WIDTH]), 64'(i));
            chk("same7_pending", 64'(pending[7]), 64'(i < 3));
        end

        // Randomized traffic; a request is held until it is accepted
        hv = 1'b0;
        ha = '0;
        hd = '0;
        for (int i = 0; i < 300; i++) begin
            if (!hv && $urandom_range(0, 3) != 0) begin
                hv = 1'b1;
                ha = 5'($urandom_range(0, 31));
                hd = $urandom;
                if ($urandom_range(0, 3) == 0) ha = 5'd7;
            end
            step(hv, ha, hd, $urandom_range(0, 2) != 0, acc);
            if (acc) hv = 1'b0;
        end
        for (int i = 0; i < 6; i++) step(1'b0, 5'd0, 32'd0, 1'b1, acc);

        // Asynchronous reset mid-cycle with entries queued
        for (int i = 0; i < 3; i++) step(1'b1, 5'(20 + i), 32'(32'hC0 + i), 1'b0, acc);
        chk("prereset_count", 64'(count), 64'd3);
        #2;
        reset_n = 1'b0;
        #1;
        mq.delete();
        for (int r = 0; r < 32; r++) mregs[r] = '0;
        wif.wr_valid = 1'b0;
        chk_state("async_reset");
        @(posedge clock);
        @(negedge clock);
        reset_n = 1'b1;
        for (int i = 0; i < 3; i++) step(1'b0, 5'd0, 32'd0, 1'b1, acc);
        chk_state("post_reset");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
